// File: rtl/exec_arith_unit.sv
// Execute-stage arithmetic block: one ALU plus the PC+step and branch-target
// adders, with every result registered. Inputs taken on a rising edge appear
// on the outputs right after that edge.
//
// Handshake: valid_in qualifies a, b, alu_sel, pc and imm in the cycle it is
// high. valid_out is valid_in delayed by one cycle. There is no ready signal
// and no backpressure. While valid_in is low the result registers keep their
// last values and only valid_out drops.
module exec_arith_unit #(
  parameter int WIDTH   = 64,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             valid_out,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [WIDTH-1:0] r;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHW-1:0]   shamt;

  // Only the low bits of b select the shift distance.
  assign shamt = b[SHW-1:0];

  // Both carry chains are kept one bit wider so their carry-out is visible.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // Combinational ALU result plus carry/overflow flags for ADD and SUB.
  always_comb begin
    r      = '0;
    r_cout = 1'b0;
    r_ovf  = 1'b0;
    case (alu_sel)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD: begin
        r      = sum_ext[WIDTH-1:0];
        r_cout = sum_ext[WIDTH];
        r_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r      = diff_ext[WIDTH-1:0];
        r_cout = diff_ext[WIDTH];
        r_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  r = a << shamt;
      OP_SRL:  r = a >> shamt;
      OP_SRA:  r = $signed(a) >>> shamt;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
  end

  // Output registers: cleared by reset, loaded only on a valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out     <= 1'b0;
      alu_out       <= '0;
      zero          <= 1'b0;
      cout          <= 1'b0;
      overflow      <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        alu_out       <= r;
        zero          <= (r == '0);
        cout          <= r_cout;
        overflow      <= r_ovf;
        pc_plus4      <= pc + WIDTH'(PC_STEP);
        branch_target <= pc + (imm << 1);
      end
    end
  end

endmodule

// File: tb/tb_exec_arith_unit.sv
// Bench for exec_arith_unit: directed cases for reset, wrap-around, flags,
// shifts and hold behaviour, followed by randomized traffic checked against
// a bit-level reference model of the instruction semantics.
module tb_exec_arith_unit;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid_in;
  logic [W-1:0] a, b, pc, imm;
  logic [3:0]   alu_sel;
  logic         valid_out, zero, cout, overflow;
  logic [W-1:0] alu_out, pc_plus4, branch_target;

  exec_arith_unit #(.WIDTH(W), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b),
    .alu_sel(alu_sel), .pc(pc), .imm(imm),
    .valid_out(valid_out), .alu_out(alu_out), .zero(zero), .cout(cout),
    .overflow(overflow), .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         e_valid, e_zero, e_cout, e_ovf;
  logic [W-1:0] e_alu, e_pc4, e_bt;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics written per bit / with wide signed arithmetic.
  function automatic void ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [3:0] s, output logic [W-1:0] r,
                                  output logic c, output logic v);
    int sh;
    logic [W:0] wide;
    logic signed [W:0] sw;
    r = '0; c = 1'b0; v = 1'b0;
    sh = int'(y[5:0]);
    case (s)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b1100: r = ~(x | y);
      4'b0010: begin
        wide = {1'b0, x} + {1'b0, y};
        r = wide[W-1:0];
        c = wide[W];
        sw = $signed({x[W-1], x}) + $signed({y[W-1], y});
        v = (sw[W] != sw[W-1]);
      end
      4'b0110: begin
        r = x - y;
        c = (x >= y);
        sw = $signed({x[W-1], x}) - $signed({y[W-1], y});
        v = (sw[W] != sw[W-1]);
      end
      4'b0100: for (int i = 0; i < W; i++) r[i] = (i >= sh) ? x[i-sh] : 1'b0;
      4'b0101: for (int i = 0; i < W; i++) r[i] = (i + sh < W) ? x[i+sh] : 1'b0;
      4'b0111: for (int i = 0; i < W; i++) r[i] = (i + sh < W) ? x[i+sh] : x[W-1];
      4'b1000: r[0] = (x[W-1] != y[W-1]) ? x[W-1] : (x < y);
      4'b1001: r[0] = (x < y);
      default: r = '0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r_, input logic v_, input logic [W-1:0] a_,
                      input logic [W-1:0] b_, input logic [3:0] s_,
                      input logic [W-1:0] pc_, input logic [W-1:0] imm_);
    logic [W-1:0] rr;
    logic cc, vv;
    rst = r_; valid_in = v_; a = a_; b = b_; alu_sel = s_; pc = pc_; imm = imm_;
    @(posedge clk);
    if (r_) begin
      e_valid = 1'b0; e_alu = '0; e_zero = 1'b0; e_cout = 1'b0; e_ovf = 1'b0;
      e_pc4 = '0; e_bt = '0;
    end else begin
      e_valid = v_;
      if (v_) begin
        ref_alu(a_, b_, s_, rr, cc, vv);
        e_alu = rr; e_zero = (rr == 0); e_cout = cc; e_ovf = vv;
        e_pc4 = pc_ + 64'd4;
        e_bt  = pc_ + {imm_[W-2:0], 1'b0};
      end
    end
    exp_q.push_back(e_alu);
    #1;
    check("valid_out", W'(valid_out), W'(e_valid));
    check("alu_out", alu_out, exp_q.pop_front());
    check("zero", W'(zero), W'(e_zero));
    check("cout", W'(cout), W'(e_cout));
    check("overflow", W'(overflow), W'(e_ovf));
    check("pc_plus4", pc_plus4, e_pc4);
    check("branch_target", branch_target, e_bt);
  endtask

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; valid_in = 1'b0; a = '0; b = '0; alu_sel = '0; pc = '0; imm = '0;
    e_valid = 1'b0; e_alu = '0; e_zero = 1'b0; e_cout = 1'b0; e_ovf = 1'b0;
    e_pc4 = '0; e_bt = '0;

    // Reset held for two cycles while an ADD is presented.
    step(1, 1, 64'd5, 64'd7, 4'b0010, 64'h100, 64'd2);
    step(1, 1, 64'd5, 64'd7, 4'b0010, 64'h100, 64'd2);
    check("rst_alu", alu_out, 64'd0);
    check("rst_valid", W'(valid_out), 64'd0);
    check("rst_pc4", pc_plus4, 64'd0);
    step(0, 1, 64'd5, 64'd7, 4'b0010, 64'h100, 64'd2);
    check("t1_alu", alu_out, 64'd12);
    check("t1_zero", W'(zero), 64'd0);

    // ADD wrap.
    step(0, 1, '1, 64'd1, 4'b0010, 64'h0, 64'h0);
    check("t2_alu", alu_out, 64'd0);
    check("t2_zero", W'(zero), 64'd1);
    check("t2_cout", W'(cout), 64'd1);
    check("t2_ovf", W'(overflow), 64'd0);

    // SUB overflow and borrow.
    step(0, 1, 64'h8000_0000_0000_0000, 64'd1, 4'b0110, 64'h0, 64'h0);
    check("t3_alu", alu_out, 64'h7FFF_FFFF_FFFF_FFFF);
    check("t3_ovf", W'(overflow), 64'd1);
    check("t3_cout", W'(cout), 64'd1);
    step(0, 1, 64'd3, 64'd5, 4'b0110, 64'h0, 64'h0);
    check("t3b_alu", alu_out, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t3b_cout", W'(cout), 64'd0);

    // Shifts and compares.
    step(0, 1, 64'h8000_0000_0000_0010, 64'h104, 4'b0100, 64'h0, 64'h0);
    check("t4_sll", alu_out, 64'h100);
    step(0, 1, 64'h8000_0000_0000_0010, 64'h104, 4'b0101, 64'h0, 64'h0);
    check("t4_srl", alu_out, 64'h0800_0000_0000_0001);
    step(0, 1, 64'h8000_0000_0000_0010, 64'h104, 4'b0111, 64'h0, 64'h0);
    check("t4_sra", alu_out, 64'hF800_0000_0000_0001);
    step(0, 1, 64'h8000_0000_0000_0010, 64'h104, 4'b1000, 64'h0, 64'h0);
    check("t4_slt", alu_out, 64'd1);
    step(0, 1, 64'h8000_0000_0000_0010, 64'h104, 4'b1001, 64'h0, 64'h0);
    check("t4_sltu", alu_out, 64'd0);

    // Address adders.
    step(0, 1, 64'd0, 64'd0, 4'b0000, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
    check("t5_pc4", pc_plus4, 64'h104);
    check("t5_bt", branch_target, 64'hF0);
    step(0, 1, 64'd0, 64'd0, 4'b0000, '1, 64'd0);
    check("t5_pc4_wrap", pc_plus4, 64'd3);

    // Hold on valid_in=0, then back-to-back valid ops.
    step(0, 1, 64'hFF, 64'h0F, 4'b0000, 64'h40, 64'd1);
    check("t6_and", alu_out, 64'h0F);
    step(0, 0, 64'h1234, 64'h5678, 4'b0010, 64'h80, 64'd3);
    check("t6_hold", alu_out, 64'h0F);
    check("t6_vout", W'(valid_out), 64'd0);
    step(0, 1, 64'd1, 64'd2, 4'b0010, 64'h0, 64'h0);
    check("t6_b2b0", alu_out, 64'd3);
    step(0, 1, 64'd10, 64'd4, 4'b0110, 64'h0, 64'h0);
    check("t6_b2b1", alu_out, 64'd6);

    // Reserved encodings.
    step(0, 1, '1, '1, 4'b1111, 64'h0, 64'h0);
    check("rsvd_alu", alu_out, 64'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           rnd64(), rnd64(), 4'($urandom_range(0, 15)), rnd64(), rnd64());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
